// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the memory arbiter: access sizes, FSM states, owner codes
// and the alignment rule for data accesses.
package mem_arbiter_pkg;

    localparam logic [1:0] LS_B        = 2'b00;
    localparam logic [1:0] LS_H        = 2'b01;
    localparam logic [1:0] LS_W        = 2'b10;
    localparam int         LS_UNSIGNED = 2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    typedef enum logic {
        OWN_INST = 1'b0,
        OWN_DATA = 1'b1
    } owner_e;

    // Any size other than B or H is treated as a word access.
    function automatic logic misaligned(input logic [1:0] size, input logic [1:0] off);
        case (size)
            LS_B:    return 1'b0;
            LS_H:    return off[0];
            default: return off != 2'b00;
        endcase
    endfunction

endpackage

// File: rtl/mem_lane.sv
// Byte-lane steering: byte enables and store-data replication on the way out,
// shift and sign/zero extension of load data on the way back.
module mem_lane
    import mem_arbiter_pkg::*;
(
    input  logic [2:0]  i_type,
    input  logic [1:0]  i_off,
    input  logic [31:0] i_wdata,
    input  logic [31:0] i_rdata,
    output logic [3:0]  o_be,
    output logic [31:0] o_wdata,
    output logic [31:0] o_rdata
);

    logic [31:0] w_shift;
    logic        w_sext;

    always_comb begin
        w_shift = i_rdata >> {i_off, 3'b000};
        w_sext  = ~i_type[LS_UNSIGNED];
        // NOTE: every branch, including default, drives all three outputs, so no latch is inferred.
        case (i_type[1:0])
            LS_B: begin
                o_be    = 4'b0001 << i_off;
                o_wdata = {4{i_wdata[7:0]}};
                o_rdata = {{24{w_shift[7] & w_sext}}, w_shift[7:0]};
            end
            LS_H: begin
                o_be    = 4'b0011 << {i_off[1], 1'b0};
                o_wdata = {2{i_wdata[15:0]}};
                o_rdata = {{16{w_shift[15] & w_sext}}, w_shift[15:0]};
            end
            default: begin
                o_be    = 4'b1111;
                o_wdata = i_wdata;
                o_rdata = w_shift;
            end
        endcase
    end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one single-port memory bus between instruction fetch and data load/store,
// one outstanding transaction at a time, stalling the core via hold until its access completes.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int AW        = 32,
    parameter int DW        = 32,
    parameter int PRIO_DATA = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_req,
    input  logic [AW-1:0] i_addr,
    output logic [DW-1:0] i_rdata,
    output logic          i_ack,
    input  logic          d_req,
    input  logic          d_we,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    input  logic [2:0]    d_type,
    output logic [DW-1:0] d_rdata,
    output logic          d_ack,
    output logic          d_err,
    output logic          hold,
    output logic          m_req,
    output logic          m_we,
    output logic [AW-1:0] m_addr,
    output logic [DW-1:0] m_wdata,
    output logic [3:0]    m_be,
    input  logic          m_gnt,
    input  logic          m_rvalid,
    input  logic [DW-1:0] m_rdata
);

    state_e        r_state;
    owner_e        r_owner;
    owner_e        r_last;
    logic          r_we;
    logic [AW-1:0] r_addr;
    logic [2:0]    r_type;
    logic [DW-1:0] r_wdata;
    logic          r_i_ack;
    logic          r_d_ack;
    logic          r_d_err;
    logic [DW-1:0] r_i_rdata;
    logic [DW-1:0] r_d_rdata;

    logic          w_pick_data;
    logic          w_start;
    logic          w_misalign;
    logic          w_done;
    logic [3:0]    w_be;
    logic [DW-1:0] w_wdata;
    logic [DW-1:0] w_load;

    always_comb begin
        if (i_req && d_req)
            w_pick_data = (PRIO_DATA != 0) ? 1'b1 : (r_last == OWN_INST);
        else
            w_pick_data = d_req;
    end

    // Arbitration is blocked while an ack is out, which spaces back-to-back accesses.
    assign w_start    = (r_state == ST_IDLE) && !r_i_ack && !r_d_ack && (i_req || d_req);
    assign w_misalign = misaligned(d_type[1:0], d_addr[1:0]);
    assign w_done     = ((r_state == ST_ADDR) && m_gnt && m_rvalid) ||
                        ((r_state == ST_RESP) && m_rvalid);

    mem_lane u_lane (
        .i_type  (r_type),
        .i_off   (r_addr[1:0]),
        .i_wdata (r_wdata),
        .i_rdata (m_rdata),
        .o_be    (w_be),
        .o_wdata (w_wdata),
        .o_rdata (w_load)
    );

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (rst) begin
            r_state   <= ST_IDLE;
            r_owner   <= OWN_INST;
            r_last    <= OWN_INST;
            r_we      <= 1'b0;
            r_addr    <= '0;
            r_type    <= '0;
            r_wdata   <= '0;
            r_i_ack   <= 1'b0;
            r_d_ack   <= 1'b0;
            r_d_err   <= 1'b0;
            r_i_rdata <= '0;
            r_d_rdata <= '0;
        end else begin
            r_i_ack <= 1'b0;
            r_d_ack <= 1'b0;
            r_d_err <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_start) begin
                        if (w_pick_data && w_misalign) begin
                            r_d_ack <= 1'b1;
                            r_d_err <= 1'b1;
                        end else begin
                            r_state <= ST_ADDR;
                            r_owner <= w_pick_data ? OWN_DATA : OWN_INST;
                            r_we    <= w_pick_data & d_we;
                            r_addr  <= w_pick_data ? d_addr : i_addr;
                            r_type  <= w_pick_data ? d_type : {1'b0, LS_W};
                            r_wdata <= d_wdata;
                        end
                    end
                end
                ST_ADDR: begin
                    if (m_gnt && !m_rvalid)
                        r_state <= ST_RESP;
                end
                ST_RESP: ;
                default: r_state <= ST_IDLE;
            endcase
            if (w_done) begin
                r_state <= ST_IDLE;
                r_last  <= r_owner;
                if (r_owner == OWN_DATA) begin
                    r_d_ack   <= 1'b1;
                    r_d_rdata <= w_load;
                end else begin
                    r_i_ack   <= 1'b1;
                    r_i_rdata <= m_rdata;
                end
            end
        end
    end

    assign i_ack   = r_i_ack;
    assign i_rdata = r_i_rdata;
    assign d_ack   = r_d_ack;
    assign d_err   = r_d_err;
    assign d_rdata = r_d_rdata;
    assign hold    = (i_req & ~r_i_ack) | (d_req & ~r_d_ack);

    assign m_req   = (r_state == ST_ADDR);
    assign m_we    = r_we & (r_state != ST_IDLE);
    assign m_addr  = {r_addr[AW-1:2], 2'b00};
    assign m_wdata = w_wdata;
    assign m_be    = (r_state == ST_IDLE) ? 4'b0000 : (r_we ? w_be : 4'b1111);

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed cases plus randomized transactions
// checked against a transaction-level model of arbitration, lanes and load extension.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_req, d_req, d_we, m_gnt, m_rvalid;
    logic [31:0] i_addr, d_addr, d_wdata, m_rdata;
    logic [2:0]  d_type;
    logic [31:0] i_rdata, d_rdata, m_addr, m_wdata;
    logic        i_ack, d_ack, d_err, hold, m_req, m_we;
    logic [3:0]  m_be;

    logic        rr_i_req, rr_d_req;
    logic [31:0] rr_i_rdata, rr_d_rdata, rr_m_addr, rr_m_wdata;
    logic        rr_i_ack, rr_d_ack, rr_d_err, rr_hold, rr_m_req, rr_m_we;
    logic [3:0]  rr_m_be;
    logic [31:0] rr_zero = 32'h0;
    logic        rr_gnt, rr_rvalid;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    mem_arbiter #(.AW(32), .DW(32), .PRIO_DATA(1)) u_dut (
        .clk(clk), .rst(rst),
        .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_ack(i_ack),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_type(d_type),
        .d_rdata(d_rdata), .d_ack(d_ack), .d_err(d_err), .hold(hold),
        .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata), .m_be(m_be),
        .m_gnt(m_gnt), .m_rvalid(m_rvalid), .m_rdata(m_rdata)
    );

    // Round-robin instance on a zero-wait bus that answers in the address cycle.
    assign rr_gnt    = rr_m_req;
    assign rr_rvalid = rr_m_req;

    mem_arbiter #(.AW(32), .DW(32), .PRIO_DATA(0)) u_rr (
        .clk(clk), .rst(rst),
        .i_req(rr_i_req), .i_addr(rr_zero), .i_rdata(rr_i_rdata), .i_ack(rr_i_ack),
        .d_req(rr_d_req), .d_we(1'b0), .d_addr(rr_zero), .d_wdata(rr_zero), .d_type(3'b010),
        .d_rdata(rr_d_rdata), .d_ack(rr_d_ack), .d_err(rr_d_err), .hold(rr_hold),
        .m_req(rr_m_req), .m_we(rr_m_we), .m_addr(rr_m_addr), .m_wdata(rr_m_wdata), .m_be(rr_m_be),
        .m_gnt(rr_gnt), .m_rvalid(rr_rvalid), .m_rdata(32'hC0DE_0001)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %08h expected %08h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    // ---- reference model ----
    function automatic logic is_misal(input logic [2:0] t, input logic [31:0] a);
        if (t[1:0] == 2'b00) return 1'b0;
        if (t[1:0] == 2'b01) return a[0];
        return a[1:0] != 2'b00;
    endfunction

    function automatic logic [3:0] exp_be(input logic we, input logic [2:0] t, input logic [31:0] a);
        if (!we) return 4'hF;
        if (t[1:0] == 2'b00) return 4'(1 << a[1:0]);
        if (t[1:0] == 2'b01) return a[1] ? 4'b1100 : 4'b0011;
        return 4'hF;
    endfunction

    function automatic logic [31:0] exp_wdata(input logic [2:0] t, input logic [31:0] wd);
        logic [31:0] r;
        int src;
        for (int j = 0; j < 4; j++) begin
            if (t[1:0] == 2'b00)      src = 0;
            else if (t[1:0] == 2'b01) src = j % 2;
            else                      src = j;
            r[8*j +: 8] = wd[8*src +: 8];
        end
        return r;
    endfunction

    function automatic logic [31:0] exp_load(input logic [2:0] t, input logic [31:0] a, input logic [31:0] rd);
        int          off;
        logic [7:0]  b;
        logic [15:0] h;
        off = int'(a[1:0]);
        if (t[1:0] == 2'b00) begin
            b = rd[8*off +: 8];
            if (!t[2] && b >= 8'h80) return 32'hFFFF_FF00 | 32'(b);
            return 32'(b);
        end
        if (t[1:0] == 2'b01) begin
            h = rd[8*off +: 16];
            if (!t[2] && h >= 16'h8000) return 32'hFFFF_0000 | 32'(h);
            return 32'(h);
        end
        return rd;
    endfunction

    // Serve one access; arbitration happens at the next rising edge.
    task automatic serve(input logic own_d, input int gd, input int rd,
                         input logic [31:0] rdata, input logic drop);
        logic [31:0] a, wd;
        logic [2:0]  t;
        logic        we;
        if (own_d) begin a = d_addr; t = d_type; we = d_we; wd = d_wdata; end
        else       begin a = i_addr; t = 3'b010; we = 1'b0; wd = 32'h0; end
        step();
        if (own_d && is_misal(t, a)) begin
            check("misal_mreq", 32'(m_req), 0);
            check("misal_dack", 32'(d_ack), 1);
            check("misal_derr", 32'(d_err), 1);
            check("misal_iack", 32'(i_ack), 0);
            check("misal_hold", 32'(hold), 32'(i_req));
        end else begin
            check("addr_mreq", 32'(m_req), 1);
            check("addr_maddr", m_addr, a & ~32'h3);
            check("addr_mwe", 32'(m_we), 32'(we));
            check("addr_mbe", 32'(m_be), 32'(exp_be(we, t, a)));
            if (we) check("addr_mwdata", m_wdata, exp_wdata(t, wd));
            check("addr_hold", 32'(hold), 1);
            if (drop) begin
                if (own_d) d_req = 1'b0; else i_req = 1'b0;
            end
            for (int k = 0; k < gd; k++) begin
                m_gnt = 1'b0; m_rvalid = 1'b0; m_rdata = $urandom;
                step();
                check("wait_mreq", 32'(m_req), 1);
                check("wait_maddr", m_addr, a & ~32'h3);
            end
            m_gnt = 1'b1; m_rvalid = (rd == 0); m_rdata = (rd == 0) ? rdata : $urandom;
            step();
            m_gnt = 1'b0; m_rvalid = 1'b0;
            for (int k = 1; k <= rd; k++) begin
                check("resp_mreq", 32'(m_req), 0);
                check("resp_noack", 32'(i_ack | d_ack), 0);
                m_gnt = 1'($urandom % 2); m_rvalid = (k == rd);
                m_rdata = (k == rd) ? rdata : $urandom;
                step();
                m_gnt = 1'b0; m_rvalid = 1'b0;
            end
            if (own_d) begin
                check("done_dack", 32'(d_ack), 1);
                check("done_derr", 32'(d_err), 0);
                check("done_iack", 32'(i_ack), 0);
                if (!we) check("done_drdata", d_rdata, exp_load(t, a, rdata));
                check("done_hold", 32'(hold), 32'(i_req));
            end else begin
                check("done_iack", 32'(i_ack), 1);
                check("done_dack", 32'(d_ack), 0);
                check("done_irdata", i_rdata, rdata);
                check("done_hold", 32'(hold), 32'(d_req));
            end
        end
        if (own_d) d_req = 1'b0; else i_req = 1'b0;
        // Stray bus strobes in the completion cycle must be ignored.
        m_gnt = 1'($urandom % 2); m_rvalid = 1'($urandom % 2);
        step();
        m_gnt = 1'b0; m_rvalid = 1'b0;
        check("gap_mreq", 32'(m_req), 0);
        check("gap_ack", 32'(i_ack | d_ack), 0);
        check("gap_hold", 32'(hold), 32'(i_req | d_req));
    endtask

    // mode 0 = fetch only, 1 = data only, 2 = both at once.
    task automatic do_txn(input int mode, input logic [31:0] ia, input logic [31:0] da,
                          input logic [2:0] dt, input logic dwe, input logic [31:0] dwd,
                          input int gd, input int rd, input logic [31:0] rdi,
                          input logic [31:0] rdd, input logic drop);
        i_req = (mode != 1); d_req = (mode != 0);
        i_addr = ia; d_addr = da; d_type = dt; d_we = dwe; d_wdata = dwd;
        m_gnt = 1'b0; m_rvalid = 1'b0;
        #1 check("req_hold", 32'(hold), 1);
        if (mode == 2) begin
            serve(1'b1, gd, rd, rdd, 1'b0);
            serve(1'b0, gd, rd, rdi, 1'b0);
        end else begin
            serve(mode == 1, gd, rd, (mode == 1) ? rdd : rdi, drop);
        end
    endtask

    task automatic rr_wait(output logic got_i, output logic got_d);
        got_i = 1'b0; got_d = 1'b0;
        for (int k = 0; k < 12; k++) begin
            step();
            if (rr_i_ack || rr_d_ack) begin
                got_i = rr_i_ack; got_d = rr_d_ack;
                return;
            end
        end
    endtask

    initial begin
        logic gi, gdd;
        rst = 1'b1;
        i_req = 0; d_req = 0; d_we = 0; m_gnt = 0; m_rvalid = 0;
        i_addr = 0; d_addr = 0; d_wdata = 0; d_type = 3'b010; m_rdata = 0;
        rr_i_req = 0; rr_d_req = 0;
        step(); step();
        rst = 1'b0;
        check("rst_iack", 32'(i_ack), 0);
        check("rst_dack", 32'(d_ack), 0);
        check("rst_derr", 32'(d_err), 0);
        check("rst_mreq", 32'(m_req), 0);
        check("rst_mwe", 32'(m_we), 0);
        check("rst_mbe", 32'(m_be), 0);
        check("rst_irdata", i_rdata, 0);
        check("rst_drdata", d_rdata, 0);
        check("rst_hold", 32'(hold), 0);
        step();

        do_txn(0, 32'h100, 0, 3'b010, 0, 0, 0, 0, 32'h0050_0093, 0, 0);
        do_txn(1, 0, 32'h203, 3'b000, 0, 0, 0, 0, 0, 32'h80FF_FFFF, 0);
        do_txn(1, 0, 32'h203, 3'b100, 0, 0, 0, 1, 0, 32'h80FF_FFFF, 0);
        do_txn(1, 0, 32'h402, 3'b001, 1, 32'h1234_ABCD, 0, 2, 0, 32'h0, 0);
        do_txn(2, 32'h80, 32'h84, 3'b010, 0, 0, 0, 0, 32'h1111_1111, 32'h2222_2222, 0);
        do_txn(1, 0, 32'h500, 3'b010, 1, 32'hDEAD_BEEF, 3, 1, 0, 32'h0, 0);
        do_txn(1, 0, 32'h202, 3'b010, 0, 0, 0, 0, 0, 32'h0, 0);
        do_txn(2, 32'h40, 32'h202, 3'b010, 0, 0, 1, 0, 32'h3333_3333, 32'h0, 0);

        for (int n = 0; n < 80; n++) begin
            int   mode;
            logic [2:0] dt;
            mode = int'($urandom % 3);
            dt   = {1'($urandom % 2), 2'($urandom % 3)};
            do_txn(mode, $urandom & 32'hFFFF_FFFC, $urandom, dt, 1'($urandom % 2), $urandom,
                   int'($urandom % 4), int'($urandom % 3), $urandom, $urandom,
                   (mode != 2) && ($urandom % 4 == 0));
        end

        // Reset while waiting for the response; the late response must vanish.
        i_req = 0; d_req = 1; d_addr = 32'h300; d_type = 3'b010; d_we = 0;
        step();
        check("rstx_mreq", 32'(m_req), 1);
        m_gnt = 1; m_rvalid = 0;
        step();
        m_gnt = 0;
        check("rstx_resp", 32'(m_req), 0);
        rst = 1; d_req = 0;
        step();
        rst = 0; m_rvalid = 1; m_rdata = 32'h5555_AAAA;
        step();
        m_rvalid = 0;
        check("rstx_dack", 32'(d_ack), 0);
        check("rstx_mreq2", 32'(m_req), 0);
        check("rstx_idle", 32'(m_be), 0);
        step();
        check("rstx_dack2", 32'(d_ack | i_ack), 0);

        // Round-robin ties: last starts as INST, so the first tie goes to data.
        rr_i_req = 1; rr_d_req = 1;
        rr_wait(gi, gdd);
        check("rr_tie1_d", 32'(gdd), 1);
        check("rr_tie1_i", 32'(gi), 0);
        rr_d_req = 0;
        rr_wait(gi, gdd);
        check("rr_tie1_next_i", 32'(gi), 1);
        rr_i_req = 0;
        step();
        rr_d_req = 1;
        rr_wait(gi, gdd);
        check("rr_solo_d", 32'(gdd), 1);
        rr_d_req = 0;
        step();
        rr_i_req = 1; rr_d_req = 1;
        rr_wait(gi, gdd);
        check("rr_tie2_i", 32'(gi), 1);
        check("rr_tie2_d", 32'(gdd), 0);
        rr_i_req = 0;
        rr_wait(gi, gdd);
        check("rr_tie2_next_d", 32'(gdd), 1);
        rr_d_req = 0;
        step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
